// File: rtl/quiz_round_controller_pkg.sv
// rtl/quiz_round_controller_pkg.sv - shared state encoding, defaults and helpers for the quiz round controller
package quiz_pkg;

    // Controller states; encoding 3 is unused and behaves as IDLE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ANSWER = 2'd2
    } quiz_state_t;

    localparam int N_PLAYERS_DEF = 4;
    localparam int SCORE_W_DEF   = 8;

    // Increment that sticks at the all-ones value of a width-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/quiz_round_controller_if.sv
// rtl/quiz_round_controller_if.sv - host/buzzer bundle between the quiz host and the round controller
interface quiz_round_controller_if
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS = N_PLAYERS_DEF,
    parameter int SCORE_W   = SCORE_W_DEF
);
    logic [N_PLAYERS-1:0]         buzz;
    logic                         arm;
    logic                         judge_valid;
    logic                         judge_correct;
    logic                         score_clr;
    logic [N_PLAYERS-1:0]         winner;
    logic                         winner_valid;
    logic [N_PLAYERS-1:0]         lockout;
    logic                         answer_timeout;
    logic                         round_done;
    logic [1:0]                   state_o;
    logic [N_PLAYERS*SCORE_W-1:0] score;

    modport master (
        output buzz, arm, judge_valid, judge_correct, score_clr,
        input  winner, winner_valid, lockout, answer_timeout, round_done, state_o, score
    );

    modport slave (
        input  buzz, arm, judge_valid, judge_correct, score_clr,
        output winner, winner_valid, lockout, answer_timeout, round_done, state_o, score
    );
endinterface

// File: rtl/quiz_round_controller_rr_arbiter.sv
// rtl/quiz_round_controller_rr_arbiter.sv - combinational round-robin grant starting at ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    logic [N-1:0] rot_req;
    logic [N-1:0] rot_gnt;
    logic         found;

    // Rotate so that bit 0 is the player at ptr; the shift by N when ptr is 0 yields zero
    assign rot_req = (req >> ptr) | (req << (N - int'(ptr)));

    // Fixed-priority pick of the lowest rotated requester
    always_comb begin
        rot_gnt = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (rot_req[i] && !found) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Rotate the grant back to player numbering
    assign gnt = (rot_gnt << ptr) | (rot_gnt >> (N - int'(ptr)));

endmodule

// File: rtl/quiz_round_controller.sv
// rtl/quiz_round_controller.sv - fastest-finger quiz round sequencer with lockout and scores
module quiz_round_controller
    import quiz_pkg::*;
#(
    parameter int N_PLAYERS     = N_PLAYERS_DEF,
    parameter int ANSWER_CYCLES = 1000,
    parameter int SCORE_W       = SCORE_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    quiz_round_controller_if.slave   bus
);
    localparam int PW = $clog2(N_PLAYERS);
    localparam int TW = $clog2(ANSWER_CYCLES);

    quiz_state_t          state_q, state_n;
    logic [N_PLAYERS-1:0] buzz_s1, buzz_s2, buzz_s2_d;
    logic [N_PLAYERS-1:0] edges, req, gnt;
    logic [N_PLAYERS-1:0] winner_q, winner_n;
    logic [N_PLAYERS-1:0] lockout_q, lockout_n;
    logic [TW-1:0]        timer_q, timer_n;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_n;
    logic [PW-1:0]        win_idx, gnt_idx;
    logic                 timeout_q, timeout_n;
    logic                 done_q, done_n;
    logic                 score_inc;
    logic [SCORE_W-1:0]   score_q [N_PLAYERS];

    // Two-flop synchronizer plus a delayed copy for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buzz_s1   <= '0;
            buzz_s2   <= '0;
            buzz_s2_d <= '0;
        end else begin
            buzz_s1   <= bus.buzz;
            buzz_s2   <= buzz_s1;
            buzz_s2_d <= buzz_s2;
        end
    end

    assign edges = buzz_s2 & ~buzz_s2_d;
    assign req   = edges & ~lockout_q;

    rr_arbiter #(.N(N_PLAYERS)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    // One-hot to index for the current holder and the fresh grant
    always_comb begin
        win_idx = '0;
        gnt_idx = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (winner_q[i]) win_idx = PW'(i);
            if (gnt[i])      gnt_idx = PW'(i);
        end
    end

    // Next-state and registered-output decisions for the round
    always_comb begin
        state_n   = state_q;
        winner_n  = winner_q;
        lockout_n = lockout_q;
        timer_n   = timer_q;
        rr_ptr_n  = rr_ptr_q;
        timeout_n = 1'b0;
        done_n    = 1'b0;
        score_inc = 1'b0;
        case (state_q)
            ARMED: begin
                if (|gnt) begin
                    winner_n = gnt;
                    timer_n  = TW'(ANSWER_CYCLES - 1);
                    rr_ptr_n = (gnt_idx == PW'(N_PLAYERS - 1)) ? '0 : gnt_idx + 1'b1;
                    state_n  = ANSWER;
                end
            end
            ANSWER: begin
                if (bus.judge_valid && bus.judge_correct) begin
                    score_inc = 1'b1;
                    done_n    = 1'b1;
                    winner_n  = '0;
                    state_n   = IDLE;
                end else if (bus.judge_valid || (timer_q == '0)) begin
                    // A judgment on the expiry cycle suppresses the timeout pulse
                    timeout_n = ~bus.judge_valid;
                    lockout_n = lockout_q | winner_q;
                    winner_n  = '0;
                    if (&(lockout_q | winner_q)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = ARMED;
                    end
                end else begin
                    timer_n = timer_q - 1'b1;
                end
            end
            default: begin
                winner_n = '0;
                state_n  = IDLE;
                if (bus.arm) begin
                    lockout_n = '0;
                    state_n   = ARMED;
                end
            end
        endcase
    end

    // Round state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            lockout_q <= '0;
            timer_q   <= '0;
            rr_ptr_q  <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            winner_q  <= winner_n;
            lockout_q <= lockout_n;
            timer_q   <= timer_n;
            rr_ptr_q  <= rr_ptr_n;
            timeout_q <= timeout_n;
            done_q    <= done_n;
        end
    end

    // Score counters; a clear outranks a simultaneous correct judgment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (bus.score_clr)
                    score_q[i] <= '0;
                else if (score_inc && (win_idx == PW'(i)))
                    score_q[i] <= SCORE_W'(sat_inc(32'(score_q[i]), SCORE_W));
            end
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        assign bus.score[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    assign bus.winner         = winner_q;
    assign bus.winner_valid   = |winner_q;
    assign bus.lockout        = lockout_q;
    assign bus.answer_timeout = timeout_q;
    assign bus.round_done     = done_q;
    assign bus.state_o        = state_q;

endmodule

// File: tb/tb_quiz_round_controller.sv
// tb/tb_quiz_round_controller.sv - self-checking bench for quiz_round_controller
module tb_quiz_round_controller;
    localparam int N  = 4;
    localparam int AC = 8;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    quiz_round_controller_if #(.N_PLAYERS(N), .SCORE_W(SW)) qif ();

    quiz_round_controller #(.N_PLAYERS(N), .ANSWER_CYCLES(AC), .SCORE_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (qif.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: who holds the answer slot, for how long, who is barred, scores
    int             m_holder;
    int             m_held;
    int             m_start;
    bit             m_open;
    bit [N-1:0]     m_locked;
    int             m_score [N];
    bit             m_to;
    bit             m_done;
    logic [N-1:0]   h1, h2, h3;
    logic [N-1:0]   m_edge;
    int             m_p;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_holder = -1; m_held = 0; m_start = 0; m_open = 0; m_locked = '0;
            for (int i = 0; i < N; i++) m_score[i] = 0;
            m_to = 0; m_done = 0; h1 = '0; h2 = '0; h3 = '0;
        end else begin
            m_edge = h2 & ~h3;
            m_to = 0;
            m_done = 0;
            if (m_holder >= 0) begin
                m_held++;
                if (qif.judge_valid && qif.judge_correct) begin
                    if (m_score[m_holder] < (1 << SW) - 1) m_score[m_holder]++;
                    m_holder = -1; m_open = 0; m_done = 1;
                end else if (qif.judge_valid || m_held == AC) begin
                    m_to = !qif.judge_valid;
                    m_locked[m_holder] = 1'b1;
                    m_holder = -1;
                    if (&m_locked) begin m_open = 0; m_done = 1; end
                end
            end else if (m_open) begin
                for (int j = 0; j < N; j++) begin
                    m_p = (m_start + j) % N;
                    if (m_holder < 0 && m_edge[m_p] && !m_locked[m_p]) begin
                        m_holder = m_p; m_held = 0; m_start = (m_p + 1) % N;
                    end
                end
            end else if (qif.arm) begin
                m_open = 1; m_locked = '0;
            end
            if (qif.score_clr) for (int i = 0; i < N; i++) m_score[i] = 0;
            h3 = h2; h2 = h1; h1 = qif.buzz;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        if (chk_en && !reset) begin
            chk("cmp_winner", 32'(qif.winner), (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
            chk("cmp_winner_valid", 32'(qif.winner_valid), 32'(m_holder >= 0));
            chk("cmp_lockout", 32'(qif.lockout), 32'(m_locked));
            chk("cmp_timeout", 32'(qif.answer_timeout), 32'(m_to));
            chk("cmp_round_done", 32'(qif.round_done), 32'(m_done));
            chk("cmp_state", 32'(qif.state_o), (m_holder >= 0) ? 32'd2 : (m_open ? 32'd1 : 32'd0));
            for (int i = 0; i < N; i++)
                chk("cmp_score", 32'(qif.score[i*SW +: SW]), 32'(m_score[i]));
        end
    end

    task automatic do_reset();
        @(negedge clk); #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic do_arm();
        @(negedge clk); qif.arm = 1'b1;
        @(negedge clk); qif.arm = 1'b0;
    endtask

    task automatic press(input logic [N-1:0] m);
        @(negedge clk); qif.buzz = m;
        repeat (3) @(posedge clk);
        @(negedge clk); qif.buzz = '0;
    endtask

    task automatic judge(input logic c, input logic clr, output logic done_s, output logic to_s);
        @(negedge clk); qif.judge_valid = 1'b1; qif.judge_correct = c; qif.score_clr = clr;
        @(posedge clk); #1;
        done_s = qif.round_done;
        to_s = qif.answer_timeout;
        @(negedge clk); qif.judge_valid = 1'b0; qif.judge_correct = 1'b0; qif.score_clr = 1'b0;
    endtask

    task automatic wait_timeout(output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (qif.answer_timeout) seen = 1'b1;
        end
    endtask

    initial begin
        logic       done_s, to_s, seen;
        logic [N-1:0] m;
        qif.buzz = '0; qif.arm = 1'b0; qif.judge_valid = 1'b0;
        qif.judge_correct = 1'b0; qif.score_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0; chk_en = 1'b1;

        chk("rst_winner", 32'(qif.winner), 32'd0);
        chk("rst_state", 32'(qif.state_o), 32'd0);
        chk("rst_score", qif.score, 32'd0);

        // Single buzz: latency and correct judgment
        do_arm();
        @(negedge clk); qif.buzz = 4'b0100;
        repeat (2) @(posedge clk); #1;
        chk("lat_not_yet", 32'(qif.winner_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_winner", 32'(qif.winner), 32'b0100);
        chk("lat_valid", 32'(qif.winner_valid), 32'd1);
        @(negedge clk); qif.buzz = '0;
        judge(1'b1, 1'b0, done_s, to_s);
        chk("t1_done", 32'(done_s), 32'd1);
        chk("t1_score2", 32'(qif.score[23:16]), 32'd1);
        chk("t1_state", 32'(qif.state_o), 32'd0);

        // Simultaneous buzz, round-robin rotation
        do_reset();
        do_arm();
        press(4'b1010);
        chk("rr_first", 32'(qif.winner), 32'b0010);
        judge(1'b1, 1'b0, done_s, to_s);
        do_arm();
        press(4'b1010);
        chk("rr_second", 32'(qif.winner), 32'b1000);
        judge(1'b1, 1'b0, done_s, to_s);

        // Timeout locks the player out, question reopens
        do_arm();
        press(4'b0001);
        chk("to_winner", 32'(qif.winner), 32'b0001);
        wait_timeout(seen);
        chk("to_seen", 32'(seen), 32'd1);
        chk("to_lockout", 32'(qif.lockout), 32'b0001);
        chk("to_state", 32'(qif.state_o), 32'd1);
        @(negedge clk); qif.buzz = 4'b0001;
        repeat (6) @(posedge clk); #1;
        chk("to_rebuzz", 32'(qif.winner_valid), 32'd0);
        @(negedge clk); qif.buzz = '0;
        press(4'b1000);
        chk("to_other", 32'(qif.winner), 32'b1000);
        judge(1'b1, 1'b0, done_s, to_s);

        // Everyone answers wrong in turn
        do_arm();
        for (int p = 0; p < N; p++) begin
            m = N'(1 << p);
            press(m);
            chk("wr_winner", 32'(qif.winner), 32'(m));
            judge(1'b0, 1'b0, done_s, to_s);
            chk("wr_done", 32'(done_s), 32'(p == N - 1));
            chk("wr_no_timeout", 32'(to_s), 32'd0);
            if (p < N - 1) chk("wr_state", 32'(qif.state_o), 32'd1);
        end
        chk("wr_lockout", 32'(qif.lockout), 32'b1111);
        chk("wr_idle", 32'(qif.state_o), 32'd0);
        do_arm();
        chk("wr_arm_clears", 32'(qif.lockout), 32'd0);

        // Score saturation and clear priority
        @(negedge clk); qif.score_clr = 1'b1;
        @(negedge clk); qif.score_clr = 1'b0;
        chk("clr_all", qif.score, 32'd0);
        for (int r = 0; r < 255; r++) begin
            do_arm();
            press(4'b0010);
            judge(1'b1, 1'b0, done_s, to_s);
        end
        chk("sat_255", 32'(qif.score[15:8]), 32'd255);
        do_arm();
        press(4'b0010);
        judge(1'b1, 1'b0, done_s, to_s);
        chk("sat_stays", 32'(qif.score[15:8]), 32'd255);
        do_arm();
        press(4'b0010);
        judge(1'b1, 1'b1, done_s, to_s);
        chk("clr_wins", 32'(qif.score[15:8]), 32'd0);

        // Held button through arm never wins
        @(negedge clk); qif.buzz = 4'b0100;
        repeat (4) @(posedge clk);
        do_arm();
        repeat (6) @(posedge clk); #1;
        chk("held_no_grant", 32'(qif.winner_valid), 32'd0);
        chk("held_state", 32'(qif.state_o), 32'd1);
        @(negedge clk); qif.buzz = '0;
        press(4'b0001);
        chk("abort_winner", 32'(qif.winner), 32'b0001);
        chk("abort_state", 32'(qif.state_o), 32'd2);

        // Reset in the middle of an answer
        @(negedge clk); #2 reset = 1'b1;
        #1;
        chk("abort_winner0", 32'(qif.winner), 32'd0);
        chk("abort_valid0", 32'(qif.winner_valid), 32'd0);
        chk("abort_state0", 32'(qif.state_o), 32'd0);
        chk("abort_done0", 32'(qif.round_done), 32'd0);
        chk("abort_score0", qif.score, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(qif.round_done), 32'd0);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("abort_after", 32'(qif.state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quiz_round_controller.md
Name: quiz_round_controller

Overview:
Sequences one quiz question at a time for the fastest-finger-first buzzer system.
- Host arms the question; the first player to press is granted.
- Host judges the answer. Wrong or late answers lock that player out, and the question re-opens to the remaining players.
- Keeps per-player scores.
- Replaces the free-running latch/toggle capture with a synchronous, fair, host-controlled round.

Parameters:
N_PLAYERS, 4, number of buzzer inputs (2..8)
ANSWER_CYCLES, 1000, clk cycles a granted player has to answer (>=2)
SCORE_W, 8, width of each player's score counter

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
buzz  input  N_PLAYERS  raw player buttons, asynchronous, active-high
arm  input  1  host pulse: open a new question
judge_valid  input  1  host strobe: judgment for current winner
judge_correct  input  1  qualifies judge_valid (1 = correct)
score_clr  input  1  pulse: zero all scores
winner  output  N_PLAYERS  one-hot granted player, zero when none
winner_valid  output  1  a player currently holds the answer slot
lockout  output  N_PLAYERS  players barred for the current question
answer_timeout  output  1  one-cycle pulse when the answer timer expires
round_done  output  1  one-cycle pulse when a question closes
state_o  output  2  current FSM state encoding
score  output  N_PLAYERS*SCORE_W  packed scores, player i at [i*SCORE_W +: SCORE_W]

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, all outputs 0, scores 0, rr_ptr=0, synchronizers 0, timer 0.
- buzz passes through a 2-flop synchronizer per bit, then a rising-edge detect (sync2 & ~sync2_d). Only edges count, so a button held from before a state change never wins.
- FSM states: IDLE=0, ARMED=1, ANSWER=2 (3 unused; decodes to IDLE).
- IDLE:
  - arm -> ARMED; lockout cleared to 0 on the same edge.
  - buzz edges ignored.
- ARMED:
  - req = edges & ~lockout.
  - If req != 0: round-robin grant starting at index rr_ptr, searching upward mod N.
  - On grant: winner=grant, winner_valid=1, timer=ANSWER_CYCLES-1, rr_ptr=(granted index+1) mod N, -> ANSWER.
  - Latency: buzz high before edge 0 -> winner_valid high after edge 2.
- ANSWER:
  - Timer decrements each cycle.
  - judge_valid & judge_correct: score[w]+=1, saturating at all-ones. Pulse round_done, clear winner/winner_valid, -> IDLE.
  - judge_valid & ~judge_correct, or timer==0 without judge: lockout[w]=1 and winner cleared. answer_timeout pulses only in the timeout case.
    - If all players are then locked: round_done pulse, -> IDLE.
    - Otherwise -> ARMED.
  - Judge and timer==0 on the same cycle: the judge wins, no timeout pulse.
  - Buzz edges in ANSWER are dropped, not queued.
- arm in ARMED/ANSWER is ignored. judge_valid outside ANSWER is ignored.
- score_clr takes effect in any state. If it coincides with a correct judgment, clear wins (result 0).
- Reset mid-question aborts the question with no round_done pulse.
- winner is always one-hot or zero. winner_valid == |winner.

Decomposition:
- Package quiz_pkg holds:
  - the state enum (IDLE, ARMED, ANSWER) and its 2-bit encoding;
  - default N_PLAYERS/SCORE_W constants;
  - a saturating-increment function.
- Sub-module rr_arbiter: combinational, with inputs req[N] and ptr[$clog2(N)] and output one-hot gnt[N]. It holds no state; the pointer register lives in the controller.

Test Plan:
Bench uses ANSWER_CYCLES=8, N=4, SCORE_W=8.
- Reset, then arm, then buzz=0100 -> winner=0100 with winner_valid high 3 edges after buzz. judge correct -> score[2]=1, round_done pulse, state_o=0.
- After reset, arm, buzz=1010 in the same cycle -> winner=0010 (rr_ptr 0). Next question, buzz=1010 again -> winner=1000.
- Arm, player 0 wins, no judge for 8 cycles -> answer_timeout pulse, lockout=0001, state_o=1. Player 0 rebuzz ignored. Player 3 buzz -> winner=1000.
- Arm, then players 0..3 each win and are judged wrong in turn -> lockout=1111, round_done pulse, state_o=0. A following arm clears lockout to 0000.
- Preload score[1]=255 via 255 correct rounds, then one more correct -> stays 255. score_clr together with a correct judge -> 0.
- Buzz held high through arm -> no grant. Reset asserted in ANSWER -> all outputs 0 immediately, no round_done pulse.
